// File: rtl/d_cache_pkg.sv
// rtl/d_cache_pkg.sv - shared state encoding and address-field helpers for d_cache_sa
package d_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } state_e;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int OFS_LSB = 2;

  // Word-offset counter keeps at least one bit so single-word lines still have a counter.
  function automatic int calc_ofs_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_idx_lsb(input int words);
    return OFS_LSB + $clog2(words);
  endfunction

  function automatic int calc_tag_lsb(input int sets, input int words);
    return calc_idx_lsb(words) + $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int sets, input int words);
    return ADDR_W - calc_tag_lsb(sets, words);
  endfunction

endpackage

// File: rtl/d_cache_way.sv
// rtl/d_cache_way.sv - one cache way: valid/dirty/tag/data arrays, tag compare, one write port
module d_cache_way
  import d_cache_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WORDS = 4,
  parameter int IDX_W = 3,
  parameter int OFS_W = 2,
  parameter int TAG_W = 25
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [OFS_W-1:0]  rd_ofs_i,
  input  logic [TAG_W-1:0]  cmp_tag_i,
  output logic              hit_o,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              wr_en_i,
  input  logic [OFS_W-1:0]  wr_ofs_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              set_dirty_i,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  fill_tag_i
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS][WORDS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (wr_en_i && set_dirty_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) data_q[idx_i][wr_ofs_i] <= wr_data_i;
    if (fill_i)  tag_q[idx_i]            <= fill_tag_i;
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign hit_o   = valid_o && (tag_o == cmp_tag_i);
  assign rdata_o = data_q[idx_i][rd_ofs_i];

endmodule

// File: rtl/d_cache_sa.sv
// rtl/d_cache_sa.sv - set-associative write-back data cache; D_CACHE_STATS_EN adds hit/miss counters
module d_cache_sa
  import d_cache_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        REQ,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] W_DATA,
  output logic [31:0] R_DATA,
  output logic        STALL,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
`ifdef D_CACHE_STATS_EN
  output logic [31:0] HIT_CNT,
  output logic [31:0] MISS_CNT,
`endif
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK
);

  localparam int OFS_W   = calc_ofs_w(WORDS);
  localparam int IDX_W   = calc_idx_w(SETS);
  localparam int TAG_W   = calc_tag_w(SETS, WORDS);
  localparam int IDX_LSB = calc_idx_lsb(WORDS);
  localparam int TAG_LSB = calc_tag_lsb(SETS, WORDS);

  state_e            state_q;
  logic [OFS_W-1:0]  w_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  rtag_q;
  logic              vic_q;
  logic [SETS-1:0]   lru_q;

  logic [OFS_W-1:0]  req_ofs, rd_ofs, wr_ofs;
  logic [IDX_W-1:0]  req_idx, way_idx;
  logic [TAG_W-1:0]  req_tag, mem_tag;
  logic [1:0]        way_hit, way_valid, way_dirty, wr_en_w, fill_w;
  logic [TAG_W-1:0]  way_tag   [2];
  logic [31:0]       way_rdata [2];
  logic [31:0]       wr_data;
  logic              set_dirty, hit_any, hit_way, victim, vic_dirty, last_word, idle_req;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^ADDR[1:0];
  assign req_ofs = (WORDS > 1) ? ADDR[OFS_LSB +: OFS_W] : '0;
  assign req_idx = ADDR[IDX_LSB +: IDX_W];
  assign req_tag = ADDR[31 -: TAG_W];

  // Outside IDLE the arrays are addressed by the latched miss, not the live request.
  assign way_idx = (state_q == ST_IDLE) ? req_idx : idx_q;
  assign rd_ofs  = (state_q == ST_IDLE) ? req_ofs : w_q;

  for (genvar g = 0; g < 2; g++) begin : g_way
    if (g < WAYS) begin : g_inst
      d_cache_way #(
        .SETS(SETS), .WORDS(WORDS), .IDX_W(IDX_W), .OFS_W(OFS_W), .TAG_W(TAG_W)
      ) u_way (
        .clk_i      (CLK),
        .rst_ni     (RSTn),
        .idx_i      (way_idx),
        .rd_ofs_i   (rd_ofs),
        .cmp_tag_i  (req_tag),
        .hit_o      (way_hit[g]),
        .valid_o    (way_valid[g]),
        .dirty_o    (way_dirty[g]),
        .tag_o      (way_tag[g]),
        .rdata_o    (way_rdata[g]),
        .wr_en_i    (wr_en_w[g]),
        .wr_ofs_i   (wr_ofs),
        .wr_data_i  (wr_data),
        .set_dirty_i(set_dirty),
        .fill_i     (fill_w[g]),
        .fill_tag_i (rtag_q)
      );
    end else begin : g_tie
      assign way_hit[g]   = 1'b0;
      assign way_valid[g] = 1'b0;
      assign way_dirty[g] = 1'b0;
      assign way_tag[g]   = '0;
      assign way_rdata[g] = '0;
    end
  end

  assign hit_any   = |way_hit;
  assign hit_way   = way_hit[1];
  assign idle_req  = (state_q == ST_IDLE) && REQ;
  assign last_word = (w_q == OFS_W'(WORDS - 1));

  always_comb begin
    victim = 1'b0;
    if (!way_valid[0])                victim = 1'b0;
    else if (WAYS > 1 && !way_valid[1]) victim = 1'b1;
    else if (WAYS > 1)                victim = lru_q[req_idx];
  end
  assign vic_dirty = way_valid[victim] && way_dirty[victim];

  always_comb begin
    wr_en_w   = '0;
    fill_w    = '0;
    wr_data   = W_DATA;
    wr_ofs    = req_ofs;
    set_dirty = 1'b0;
    case (state_q)
      ST_IDLE: if (idle_req && hit_any && WE) begin
        wr_en_w[hit_way] = 1'b1;
        set_dirty        = 1'b1;
      end
      ST_REFILL: if (MEM_ACK) begin
        wr_en_w[vic_q] = 1'b1;
        fill_w[vic_q]  = last_word;
        wr_data        = MEM_RDATA;
        wr_ofs         = w_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      idx_q   <= '0;
      rtag_q  <= '0;
      vic_q   <= 1'b0;
      lru_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (REQ) begin
          if (hit_any) begin
            lru_q[req_idx] <= ~hit_way;
          end else begin
            idx_q   <= req_idx;
            rtag_q  <= req_tag;
            vic_q   <= victim;
            w_q     <= '0;
            state_q <= vic_dirty ? ST_WRITEBACK : ST_REFILL;
          end
        end
        ST_WRITEBACK: if (MEM_ACK) begin
          w_q <= last_word ? '0 : w_q + OFS_W'(1);
          if (last_word) state_q <= ST_REFILL;
        end
        ST_REFILL: if (MEM_ACK) begin
          w_q <= last_word ? '0 : w_q + OFS_W'(1);
          if (last_word) begin
            lru_q[idx_q] <= ~vic_q;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_tag   = (state_q == ST_WRITEBACK) ? way_tag[vic_q] : rtag_q;
  assign STALL     = (state_q != ST_IDLE) || (REQ && !hit_any);
  assign R_DATA    = (idle_req && !WE && hit_any) ? way_rdata[hit_way] : '0;
  assign MEM_REQ   = (state_q != ST_IDLE);
  assign MEM_WE    = (state_q == ST_WRITEBACK);
  assign MEM_WDATA = MEM_WE ? way_rdata[vic_q] : '0;
  assign MEM_ADDR  = MEM_REQ ? ((32'(mem_tag) << TAG_LSB) | (32'(idx_q) << IDX_LSB) | (32'(w_q) << 2))
                             : '0;

`ifdef D_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (idle_req) begin
      if (hit_any) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else         miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign HIT_CNT  = hit_cnt_q;
  assign MISS_CNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_d_cache_sa.sv
// tb/tb_d_cache_sa.sv - scoreboard bench for d_cache_sa with a 2-cycle and a zero-wait memory model
module tb_d_cache_sa;

  logic        CLK = 1'b0;
  logic        RSTn, REQ, WE;
  logic [31:0] ADDR, W_DATA, R_DATA, MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        STALL, MEM_REQ, MEM_WE, MEM_ACK;
`ifdef D_CACHE_STATS_EN
  logic [31:0] HIT_CNT, MISS_CNT;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic [31:0] mem [256];
  bit          mem_ready = 1'b0;
  bit          zw = 1'b0;
  logic        ack_r = 1'b0;
  int          ack_cnt = 0;
  beat_t       obs_buf [64];
  int          obs_wr = 0;
  int          obs_rd = 0;
  beat_t       mq [$];
  logic [31:0] rq [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 CLK = ~CLK;

  d_cache_sa dut (
    .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .WE(WE), .ADDR(ADDR), .W_DATA(W_DATA),
    .R_DATA(R_DATA), .STALL(STALL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
`ifdef D_CACHE_STATS_EN
    .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT),
`endif
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
  );

  assign MEM_RDATA = mem[MEM_ADDR[9:2]];
  assign MEM_ACK   = zw ? MEM_REQ : ack_r;

  // Memory model: ACK on every second requested cycle (or every cycle when zw), logs each beat.
  always @(negedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | (i << 2);
      mem[16] = 32'hDEAD_BEEF;
      mem_ready = 1'b1;
    end
    if (MEM_REQ) begin
      if (ack_cnt == 1) begin ack_r = 1'b1; ack_cnt = 0; end
      else              begin ack_r = 1'b0; ack_cnt = 1; end
    end else begin
      ack_r = 1'b0; ack_cnt = 0;
    end
    if (MEM_REQ && (zw || ack_r)) begin
      obs_buf[obs_wr % 64] = '{MEM_WE, MEM_ADDR, MEM_WDATA};
      obs_wr = obs_wr + 1;
      if (MEM_WE) mem[MEM_ADDR[9:2]] = MEM_WDATA;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_beats();
    beat_t o, e;
    while (obs_rd != obs_wr) begin
      o = obs_buf[obs_rd % 64];
      obs_rd++;
      if (mq.size() == 0) begin
        check("mem_extra_beat", o.addr, 32'hFFFF_FFFF);
      end else begin
        e = mq.pop_front();
        check($sformatf("mem_we@%h", e.addr), 32'(o.we), 32'(e.we));
        check("mem_addr", o.addr, e.addr);
        if (e.we) check($sformatf("mem_wdata@%h", e.addr), o.data, e.data);
      end
    end
  endtask

  task automatic push_reads(input logic [31:0] base);
    for (int i = 0; i < 4; i++) mq.push_back('{1'b0, base + 32'(4 * i), 32'h0});
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
    mq.push_back('{1'b1, addr, data});
  endtask

  task automatic drained(input string tag);
    compare_beats();
    check(tag, 32'(mq.size()), 32'd0);
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int exp_stall);
    int stalls = 0;
    bit done = 1'b0;
    @(posedge CLK); #1;
    REQ = 1'b1; WE = we; ADDR = addr; W_DATA = wdata;
    if (!we) rq.push_back(exp_rdata);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge CLK);
      compare_beats();
      if (!STALL) begin
        done = 1'b1;
        if (!we) check($sformatf("rdata@%h", addr), R_DATA, rq.pop_front());
      end else begin
        stalls++;
      end
    end
    check($sformatf("access_done@%h", addr), 32'(done), 32'd1);
    check($sformatf("stall_cycles@%h", addr), 32'(stalls), 32'(exp_stall));
    @(posedge CLK); #1;
    REQ = 1'b0; WE = 1'b0;
    compare_beats();
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RSTn = 1'b0; REQ = 1'b0; WE = 1'b0;
    @(posedge CLK); #1;
    RSTn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int c;
    RSTn = 1'b0; REQ = 1'b0; WE = 1'b0; ADDR = '0; W_DATA = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_stall", 32'(STALL), 32'd0);
    check("rst_mem_req", 32'(MEM_REQ), 32'd0);
    check("rst_mem_we", 32'(MEM_WE), 32'd0);
    check("rst_mem_addr", MEM_ADDR, 32'd0);
    check("rst_mem_wdata", MEM_WDATA, 32'd0);
    check("rst_rdata", R_DATA, 32'd0);
    @(posedge CLK); #1;
    RSTn = 1'b1;

    // Clean miss, then store/load hits on the same line
    push_reads(32'h40);
    access(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 9);
    drained("t1_pending");
    access(1'b1, 32'h44, 32'h1234_5678, 32'h0, 0);
    access(1'b0, 32'h44, 32'h0, 32'h1234_5678, 0);
    drained("t2_pending");
`ifdef D_CACHE_STATS_EN
    check("hit_cnt", HIT_CNT, 32'd3);
    check("miss_cnt", MISS_CNT, 32'd1);
`endif

    // LRU: 0x0C0 is least recent and clean, so 0x140 replaces it without write-back
    push_reads(32'hC0);
    access(1'b0, 32'hC0, 32'h0, 32'hA000_00C0, 9);
    access(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0);
    push_reads(32'h140);
    access(1'b0, 32'h140, 32'h0, 32'hA000_0140, 9);
    access(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0);
    access(1'b0, 32'h44, 32'h0, 32'h1234_5678, 0);
    drained("t3_pending");

    // Dirty eviction: write-back of 0x040 precedes the refill of 0x140
    do_reset();
    push_reads(32'h40);
    access(1'b1, 32'h40, 32'hCAFE_F00D, 32'h0, 9);
    push_reads(32'hC0);
    access(1'b0, 32'hC0, 32'h0, 32'hA000_00C0, 9);
    push_write(32'h40, 32'hCAFE_F00D);
    push_write(32'h44, 32'hA000_0044);
    push_write(32'h48, 32'hA000_0048);
    push_write(32'h4C, 32'hA000_004C);
    push_reads(32'h140);
    access(1'b0, 32'h140, 32'h0, 32'hA000_0140, 17);
    access(1'b0, 32'h140, 32'h0, 32'hA000_0140, 0);
    push_reads(32'h40);
    access(1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 9);
    drained("t4_pending");

    // Reset during the second refill word abandons the fill
    mq.push_back('{1'b0, 32'h80, 32'h0});
    @(posedge CLK); #1;
    REQ = 1'b1; WE = 1'b0; ADDR = 32'h80;
    base = obs_wr;
    c = 0;
    while (obs_wr == base && c < 100) begin
      @(posedge CLK);
      c++;
    end
    check("t5_first_beat", 32'(obs_wr - base), 32'd1);
    #2;
    RSTn = 1'b0; REQ = 1'b0;
    #1;
    check("t5_mem_req_in_rst", 32'(MEM_REQ), 32'd0);
    check("t5_stall_in_rst", 32'(STALL), 32'd0);
    @(posedge CLK); #1;
    RSTn = 1'b1;
    drained("t5_pending");
    push_reads(32'h80);
    access(1'b0, 32'h80, 32'h0, 32'hA000_0080, 9);
    drained("t5b_pending");

    // Zero-wait memory: one word per cycle for refill and write-back
    zw = 1'b1;
    push_reads(32'h200);
    access(1'b0, 32'h200, 32'h0, 32'hA000_0200, 5);
    access(1'b1, 32'h204, 32'h5555_AAAA, 32'h0, 0);
    push_reads(32'h280);
    access(1'b0, 32'h284, 32'h0, 32'hA000_0284, 5);
    push_write(32'h200, 32'hA000_0200);
    push_write(32'h204, 32'h5555_AAAA);
    push_write(32'h208, 32'hA000_0208);
    push_write(32'h20C, 32'hA000_020C);
    push_reads(32'h300);
    access(1'b0, 32'h300, 32'h0, 32'hA000_0300, 9);
    drained("t7_pending");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
